// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decoder.
//
// Issues sequential word-aligned fetch addresses over a valid/ready request channel,
// tracks the PC of every accepted request, and buffers in-order responses together
// with their PCs in a small prefetch FIFO. A redirect flushes the FIFO, restarts
// fetch at the new PC, and drains responses still in flight from the old path.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   mem_req_*         fetch request channel (valid/ready, 32-bit address)
//   mem_resp_*        in-order response channel (valid, 32-bit instruction word)
//   inst_*            instruction output to the decoder (valid/ready, data, pc)
//   redirect_*        taken branch/jump pulse and target PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthCnt = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic {StFetch, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [31:0]     fifo_data_d [FIFO_DEPTH];
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]     pcq_q       [FIFO_DEPTH];
    logic [31:0]     pcq_d       [FIFO_DEPTH];
    logic [PtrW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PtrW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [CntW-1:0] fifo_count_q, fifo_count_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] stale_q, stale_d;
    logic [CntW:0]   occupancy;
    logic            req_hs, pop, resp_keep, resp_stale;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Counting in-flight requests against free FIFO slots means a response always has
    // somewhere to go, so the response channel needs no back-pressure.
    assign occupancy     = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    assign mem_req_valid = !rst && (state_q == StFetch) && (occupancy < DepthCnt)
                           && !redirect_valid;
    assign mem_req_addr  = fetch_pc_q;

    assign inst_valid = (fifo_count_q != '0);
    assign inst_data  = inst_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign inst_pc    = inst_valid ? fifo_pc_q[fifo_rd_q] : '0;

    assign req_hs     = mem_req_valid && mem_req_ready;
    assign pop        = inst_valid && inst_ready;
    assign resp_stale = mem_resp_valid && (stale_q != '0);
    // Responses landing in a redirect cycle belong to the old path.
    assign resp_keep  = mem_resp_valid && (stale_q == '0) && !redirect_valid;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        fifo_data_d  = fifo_data_q;
        fifo_pc_d    = fifo_pc_q;
        pcq_d        = pcq_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        pcq_wr_d     = pcq_wr_q;
        pcq_rd_d     = pcq_rd_q;
        stale_d      = stale_q;
        inflight_d   = inflight_q + CntW'(req_hs) - CntW'(mem_resp_valid);
        fifo_count_d = fifo_count_q + CntW'(resp_keep) - CntW'(pop);

        if (req_hs) begin
            pcq_d[pcq_wr_q] = fetch_pc_q;
            pcq_wr_d        = pcq_wr_q + PtrW'(1);
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end

        if (resp_keep) begin
            fifo_data_d[fifo_wr_q] = mem_resp_data;
            fifo_pc_d[fifo_wr_q]   = pcq_q[pcq_rd_q];
            fifo_wr_d              = fifo_wr_q + PtrW'(1);
            pcq_rd_d               = pcq_rd_q + PtrW'(1);
        end

        if (pop) begin
            fifo_rd_d = fifo_rd_q + PtrW'(1);
        end

        if (resp_stale) begin
            stale_d = stale_q - CntW'(1);
        end

        if (state_q == StDrain && stale_d == '0) begin
            state_d = StFetch;
        end

        // No request is issued in a redirect cycle, so everything still in flight
        // after this edge is from the abandoned path.
        if (redirect_valid) begin
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            fifo_count_d = '0;
            fifo_wr_d    = '0;
            fifo_rd_d    = '0;
            pcq_wr_d     = '0;
            pcq_rd_d     = '0;
            stale_d      = inflight_d;
            state_d      = (inflight_d != '0) ? StDrain : StFetch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            fetch_pc_q   <= RESET_PC;
            fifo_data_q  <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
            pcq_q        <= '{default: '0};
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            pcq_wr_q     <= '0;
            pcq_rd_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            stale_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            fifo_data_q  <= fifo_data_d;
            fifo_pc_q    <= fifo_pc_d;
            pcq_q        <= pcq_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            pcq_wr_q     <= pcq_wr_d;
            pcq_rd_q     <= pcq_rd_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            stale_q      <= stale_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A behavioural memory (in-order, configurable latency) serves requests. The reference
// model keeps the expected decoder-visible instruction stream as a queue, tags each
// accepted request with a redirect epoch and drops responses from older epochs.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    typedef struct {
        int          reps;
        bit          iready;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       pend[$];    // requests accepted by memory, oldest first
    inst_t       expq[$];    // instructions the decoder should see, oldest first
    logic [31:0] popped[$];  // inst_pc values the DUT handed over
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_epoch = 0;
    int          cur_lat = 1;
    logic [31:0] model_pc = RST_PC;
    bit          cur_rdir, cur_iready, cur_mready, cur_resp_now;
    logic [31:0] cur_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit draining();
        foreach (pend[i]) begin
            if (pend[i].epoch != cur_epoch) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive one cycle's inputs at the falling edge and check outputs against the model.
    task automatic drive(input bit rdir, input logic [31:0] rpc, input bit iready,
                         input bit mready);
        bit exp_rv;
        @(negedge clk);
        cur_rdir     = rdir;
        cur_rpc      = rpc;
        cur_iready   = iready;
        cur_mready   = mready;
        cur_resp_now = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_resp_valid = cur_resp_now;
        mem_resp_data  = cur_resp_now ? (pend[0].addr ^ KEY) : 32'h0;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        inst_ready     = iready;
        mem_req_ready  = mready;
        #1;
        exp_rv = !draining() && (expq.size() + pend.size() < DEPTH) && !rdir;
        chk("req_valid", {31'b0, mem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", mem_req_addr, model_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, (expq.size() > 0)});
        if (expq.size() > 0) begin
            chk("inst_pc", inst_pc, expq[0].pc);
            chk("inst_data", inst_data, expq[0].data);
        end
    endtask

    // Advance the model to reflect what happens at the coming rising edge.
    task automatic commit();
        mreq_t e;
        if (inst_valid && cur_iready) popped.push_back(inst_pc);
        if (cur_iready && expq.size() > 0) expq.delete(0);
        if (cur_resp_now) begin
            e = pend.pop_front();
            if (e.epoch == cur_epoch && !cur_rdir) expq.push_back('{e.addr, e.addr ^ KEY});
        end
        if (mem_req_valid && cur_mready) begin
            pend.push_back('{addr: mem_req_addr, due: cyc + cur_lat, epoch: cur_epoch});
            model_pc = model_pc + 32'd4;
        end
        if (cur_rdir) begin
            cur_epoch++;
            expq.delete();
            model_pc = {cur_rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic step(input bit rdir, input logic [31:0] rpc, input bit iready,
                        input bit mready);
        drive(rdir, rpc, iready, mready);
        commit();
    endtask

    task automatic release_reset();
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        rst            = 1'b0;
        pend.delete();
        expq.delete();
        popped.delete();
        cur_epoch++;
        model_pc = RST_PC;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        release_reset();
    endtask

    vec_t tbl[10];
    int   base;
    bit   prev_rdir;
    bit   rd;

    initial begin
        // Back-pressure from reset, then release: 1-cycle memory, memory always ready.
        tbl[0] = '{1,  1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1,  1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2] = '{1,  1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3] = '{1,  1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        tbl[4] = '{16, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        tbl[5] = '{1,  1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        tbl[6] = '{1,  1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        tbl[7] = '{1,  1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        tbl[8] = '{1,  1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        tbl[9] = '{1,  1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

        do_reset();
        cur_lat = 1;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                drive(1'b0, 32'h0, tbl[r].iready, 1'b1);
                chk($sformatf("tbl%0d_rv", r), {31'b0, mem_req_valid}, {31'b0, tbl[r].rv});
                if (tbl[r].rv) chk($sformatf("tbl%0d_addr", r), mem_req_addr, tbl[r].addr);
                chk($sformatf("tbl%0d_iv", r), {31'b0, inst_valid}, {31'b0, tbl[r].iv});
                if (tbl[r].iv) chk($sformatf("tbl%0d_pc", r), inst_pc, tbl[r].pc);
                commit();
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_order%0d", i), (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF,
                32'(i * 4));
        end

        // Sequential fetch: one instruction per cycle from cycle 2.
        do_reset();
        cur_lat = 1;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("seq_count", popped.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("seq_pc%0d", i), (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF,
                32'(i * 4));
        end

        // Redirect with three requests outstanding on a 3-cycle memory.
        do_reset();
        cur_lat = 3;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            chk("drain_rv", {31'b0, mem_req_valid}, 32'd0);
            commit();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("drain_exit_addr", mem_req_addr, 32'h100);
        commit();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_pc0", (popped.size() > 0) ? popped[0] : 32'hFFFF_FFFF, 32'h100);
        chk("redir_pc1", (popped.size() > 1) ? popped[1] : 32'hFFFF_FFFF, 32'h104);

        // Misaligned redirect coinciding with a response and a pop.
        do_reset();
        cur_lat = 1;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b1, 32'h203, 1'b1, 1'b1);
        chk("mis_pop_iv", {31'b0, inst_valid}, 32'd1);
        chk("mis_pop_pc", inst_pc, 32'h0C);
        chk("mis_resp_present", {31'b0, mem_resp_valid}, 32'd1);
        commit();
        base = popped.size();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("mis_next_rv", {31'b0, mem_req_valid}, 32'd1);
        chk("mis_next_addr", mem_req_addr, 32'h200);
        chk("mis_flushed", {31'b0, inst_valid}, 32'd0);
        commit();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("mis_after_pc", (popped.size() > base) ? popped[base] : 32'hFFFF_FFFF, 32'h200);

        // Stalled memory, then a redirect retracts the pending request.
        do_reset();
        cur_lat = 2;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk("stall_rv", {31'b0, mem_req_valid}, 32'd1);
            chk("stall_addr", mem_req_addr, 32'h0);
            commit();
        end
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        chk("stall_redir_rv", {31'b0, mem_req_valid}, 32'd0);
        commit();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall_new_addr", mem_req_addr, 32'h40);
        commit();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall_first_pc", (popped.size() > 0) ? popped[0] : 32'hFFFF_FFFF, 32'h40);

        // Asynchronous reset between edges with three instructions buffered.
        do_reset();
        cur_lat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_iv", {31'b0, inst_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_iv", {31'b0, inst_valid}, 32'd0);
        chk("async_rv", {31'b0, mem_req_valid}, 32'd0);
        release_reset();
        cur_lat = 1;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("restart_addr", mem_req_addr, RST_PC);
        commit();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("restart_pc", (popped.size() > 0) ? popped[0] : 32'hFFFF_FFFF, RST_PC);

        // Randomised traffic against the model.
        do_reset();
        prev_rdir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cur_lat = int'($urandom_range(1, 4));
            rd = !prev_rdir && ($urandom_range(0, 19) == 0);
            step(rd, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            prev_rdir = rd;
        end
        chk("rand_progress", {31'b0, (popped.size() > 300)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
